seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Four-digit seven-segment scan multiplexer for the alarm display path. It sits directly downstream of the per-character pattern generators, such as the letter blocks that spell "UPUP". It takes four 7-bit segment patterns and time-multiplexes them onto one shared segment bus with a one-hot digit select. It also provides anti-ghosting guard time and per-digit blinking.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 2: blank cycles at the start of each slot; must satisfy 0 ≤ GUARD < SCAN_DIV.
- BLINK_DIV, 250: full 4-digit frames per blink half-period; must be ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scan running; 0 = display dark and counters cleared.
- seg0  input  7  digit 0 pattern, bit6..bit0 = A..G, 1 = segment lit.
- seg1  input  7  digit 1 pattern, same encoding.
- seg2  input  7  digit 2 pattern, same encoding.
- seg3  input  7  digit 3 pattern, same encoding.
- blink_en  input  4  bit d = 1 makes digit d blink.
- seg_out  output  7  registered segment bus, bit6..bit0 = A..G, active-high.
- dig_sel  output  4  registered digit select, active-low one-hot; bit d selects digit d.
- frame_tick  output  1  registered single-cycle pulse at the end of each full frame.

## Operation
- State:
  - scan_cnt, range 0..SCAN_DIV-1.
  - digit, 2 bits, range 0..3.
  - blink_cnt, range 0..BLINK_DIV-1.
  - blink_phase, 1 bit.
- Reset: all state = 0; seg_out = 7'b0000000; dig_sel = 4'b1111; frame_tick = 0.
- enable = 0, sampled at a clock edge:
  - scan_cnt, digit, blink_cnt and blink_phase are cleared to 0.
  - Next outputs are seg_out = 0, dig_sel = 4'b1111, frame_tick = 0.
- enable = 1, each cycle:
  - If scan_cnt < SCAN_DIV-1: scan_cnt increments.
  - Otherwise: scan_cnt wraps to 0 and digit advances 0→1→2→3→0.
- Frame end: scan_cnt = SCAN_DIV-1 and digit = 3, with enable = 1.
  - frame_tick = 1 on the next cycle.
  - blink_cnt increments.
  - If blink_cnt = BLINK_DIV-1, blink_cnt wraps to 0 and blink_phase toggles.
- Output decode, computed from state and inputs of the current cycle:
  - Guard: if scan_cnt < GUARD, seg_out = 0 and dig_sel = 4'b1111.
  - Otherwise dig_sel has bit "digit" = 0 and all other bits = 1.
  - seg_out = seg[digit], or 0 when blink_en[digit] = 1 and blink_phase = 1.
  - A blanked digit keeps its select asserted; only the segments go dark.
- Segment inputs are not latched; a change mid-slot appears on seg_out after the normal one-cycle latency.
- blink_en is sampled every cycle, with the same latency.
- At most one dig_sel bit is ever low.

## Timing
- Latency:
  - seg_out, dig_sel and frame_tick at cycle n+1 reflect state and inputs at cycle n.
  - State updates at the same edge.
- Slot timing: each slot is SCAN_DIV cycles, of which GUARD are blank and SCAN_DIV-GUARD are driven.
- Frame period: 4·SCAN_DIV cycles.
- Blink period: 2·BLINK_DIV frames; the visible-on phase (blink_phase = 0) comes first after reset.
- Reset assertion: outputs take reset values immediately, without waiting for a clock edge.
- Reset release: the first edge with enable = 1 starts slot 0 at scan_cnt 0.
- Reset mid-slot: the partial slot is discarded and scanning restarts at digit 0, guard first.
- enable 1→0: outputs go dark on the next edge.
- enable 0→1: behaves exactly like leaving reset; no stale digit is shown.
- Simultaneous frame end and blink wrap: frame_tick and the blink_phase toggle take effect on the same edge.
- GUARD = 0: there are no blank cycles and slots abut directly.

## Test plan
Parameters for all scenarios: SCAN_DIV = 4, GUARD = 1, BLINK_DIV = 2.
- Reset values: assert reset mid-run, asynchronously between edges → seg_out = 0000000 and dig_sel = 1111 immediately. Release with enable = 1 → the first driven cycle shows dig_sel = 1110.
- Scan order: seg0..seg3 = U 0111110, P 1100111, U, P; enable = 1, no blink. Per 4-cycle slot, expect 1 cycle blank (1111/0000000), then 3 cycles of:
  - dig_sel = 1110 with seg_out = 0111110;
  - then dig_sel = 1101 with 1100111;
  - then 1011 with 0111110;
  - then 0111 with 1100111;
  - then repeat.
- Frame and blink: frame_tick pulses exactly once every 16 cycles. With blink_en = 0010:
  - digit 1 shows 1100111 for frames 0–1;
  - digit 1 shows 0000000 with dig_sel = 1101 still asserted for frames 2–3;
  - the other digits are unaffected.
- Enable gating: drop enable during digit 2 → the next edge gives 1111/0000000 and no frame_tick. Raise enable → restart at digit 0 with a guard cycle and blink_phase = 0.
- Live input change: change seg0 from 0111110 to 1100111 in the middle of digit 0's driven cycles → seg_out shows the new value one cycle later, with no select glitch.
- Invariant check, run throughout all scenarios: dig_sel is never 0-hot-plural, and every guard cycle is fully blank.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer with per-slot guard blanking and
// per-digit blinking. All outputs are registered one cycle behind the state.
module seg_scan_mux #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned GUARD     = 2,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] blink_en,
  output logic [6:0] seg_out,
  output logic [3:0] dig_sel,
  output logic       frame_tick
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] ScanLast  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GuardEnd  = SW'(GUARD);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q;
  logic [1:0]    digit_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  logic [6:0] cur_seg;
  logic       slot_end;
  logic       frame_end;
  logic       in_guard;

  always_comb begin
    cur_seg = seg0;
    case (digit_q)
      2'd0:    cur_seg = seg0;
      2'd1:    cur_seg = seg1;
      2'd2:    cur_seg = seg2;
      default: cur_seg = seg3;
    endcase
  end

  assign slot_end  = (scan_cnt_q == ScanLast);
  assign frame_end = slot_end && (digit_q == 2'd3);
  assign in_guard  = (scan_cnt_q < GuardEnd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      digit_q       <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_out       <= 7'd0;
      dig_sel       <= 4'b1111;
      frame_tick    <= 1'b0;
    end else if (!enable) begin
      // Disabled looks exactly like reset, so re-enabling never shows a stale digit.
      scan_cnt_q    <= '0;
      digit_q       <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_out       <= 7'd0;
      dig_sel       <= 4'b1111;
      frame_tick    <= 1'b0;
    end else begin
      scan_cnt_q <= slot_end ? '0 : scan_cnt_q + SW'(1);
      if (slot_end) begin
        digit_q <= digit_q + 2'd1;
      end
      frame_tick <= frame_end;
      if (frame_end) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
      if (in_guard) begin
        seg_out <= 7'd0;
        dig_sel <= 4'b1111;
      end else begin
        // A blinked-off digit keeps its select; only the segments go dark.
        dig_sel <= ~(4'b0001 << digit_q);
        seg_out <= (blink_en[digit_q] && blink_phase_q) ? 7'd0 : cur_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: scenario tasks plus randomized traffic
// compared against a time-indexed reference model.
module tb_seg_scan_mux;

  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BD = 2;
  localparam logic [6:0] PAT_U = 7'b0111110;
  localparam logic [6:0] PAT_P = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] segs [4];
  logic [3:0] blink_en = 4'b0000;
  logic [6:0] seg_out;
  logic [3:0] dig_sel;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference: expected {frame_tick, dig_sel, seg_out} and cycles since scan start.
  logic [11:0] exp_out = {1'b0, 4'b1111, 7'd0};
  int          t = 0;

  seg_scan_mux #(
    .SCAN_DIV  (SD),
    .GUARD     (GD),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .seg0       (segs[0]),
    .seg1       (segs[1]),
    .seg2       (segs[2]),
    .seg3       (segs[3]),
    .blink_en   (blink_en),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Output for scan time tt: slot = tt/SD, digit = slot mod 4, frame = tt/(4*SD),
  // blink phase = (frame / BD) mod 2.
  function automatic logic [11:0] ref_out(input int tt, input logic [3:0] bl,
                                          input logic [27:0] pats);
    int         d;
    logic       ph;
    logic       tk;
    logic [3:0] sel;
    logic [6:0] s;
    d   = (tt / SD) % 4;
    ph  = ((tt / (4 * SD * BD)) % 2) == 1;
    tk  = (tt % (4 * SD)) == (4 * SD - 1);
    sel = 4'b1111;
    s   = 7'd0;
    if ((tt % SD) >= GD) begin
      sel[d] = 1'b0;
      s = (bl[d] && ph) ? 7'd0 : pats[7*d +: 7];
    end
    return {tk, sel, s};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      exp_out <= {1'b0, 4'b1111, 7'd0};
      t       <= 0;
    end else begin
      exp_out <= ref_out(t, blink_en, {segs[3], segs[2], segs[1], segs[0]});
      t       <= t + 1;
    end
  end

  task automatic test_reset();
    segs[0] = PAT_U; segs[1] = PAT_P; segs[2] = PAT_U; segs[3] = PAT_P;
    repeat (2) @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got sel=%b seg=%b tick=%b want 1111/0000000/0",
               dig_sel, seg_out, frame_tick);
    end
    reset = 1'b0;
    enable = 1'b1;
    repeat (7) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp_out) begin
        errors++;
        $display("FAIL reset_run got %b want %b", {frame_tick, dig_sel, seg_out}, exp_out);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got sel=%b seg=%b tick=%b want 1111/0000000/0",
               dig_sel, seg_out, frame_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_guard got sel=%b seg=%b want 1111/0000000", dig_sel, seg_out);
    end
    @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1110 || seg_out !== PAT_U) begin
      errors++;
      $display("FAIL reset_first got sel=%b seg=%b want 1110/%b", dig_sel, seg_out, PAT_U);
    end
  endtask

  task automatic test_scan();
    blink_en = 4'b0000;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp_out) begin
        errors++;
        $display("FAIL scan got %b want %b", {frame_tick, dig_sel, seg_out}, exp_out);
      end
      checks++;
      if (!$onehot0(~dig_sel) || (dig_sel === 4'b1111 && seg_out !== 7'd0)) begin
        errors++;
        $display("FAIL scan_invariant got sel=%b seg=%b want <=1 low, blank when idle",
                 dig_sel, seg_out);
      end
    end
  endtask

  task automatic test_blink();
    int dark_early = 0, dark_late = 0, lit_early = 0, ticks = 0, bad_ticks = 0;
    blink_en = 4'b0010;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp_out) begin
        errors++;
        $display("FAIL blink got %b want %b", {frame_tick, dig_sel, seg_out}, exp_out);
      end
      if (dig_sel === 4'b1101 && seg_out === 7'd0) begin
        if (i < 32) dark_early++; else dark_late++;
      end
      if (dig_sel === 4'b1101 && seg_out === PAT_P && i < 32) lit_early++;
      if (frame_tick === 1'b1) begin
        ticks++;
        if ((i % 16) != 15) bad_ticks++;
      end
    end
    checks++;
    if (dark_early != 0 || dark_late != 6 || lit_early != 6) begin
      errors++;
      $display("FAIL blink_digit1 got dark_early=%0d dark_late=%0d lit=%0d want 0/6/6",
               dark_early, dark_late, lit_early);
    end
    checks++;
    if (ticks != 4 || bad_ticks != 0) begin
      errors++;
      $display("FAIL frame_tick got count=%0d misplaced=%0d want 4/0", ticks, bad_ticks);
    end
  endtask

  task automatic test_enable();
    blink_en = 4'b1111;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (41) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp_out) begin
        errors++;
        $display("FAIL enable_run got %b want %b", {frame_tick, dig_sel, seg_out}, exp_out);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop got sel=%b seg=%b tick=%b want 1111/0000000/0",
               dig_sel, seg_out, frame_tick);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'd0) begin
      errors++;
      $display("FAIL enable_guard got sel=%b seg=%b want 1111/0000000", dig_sel, seg_out);
    end
    @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1110 || seg_out !== segs[0]) begin
      errors++;
      $display("FAIL enable_restart got sel=%b seg=%b want 1110/%b", dig_sel, seg_out, segs[0]);
    end
  endtask

  task automatic test_live();
    blink_en = 4'b0000;
    segs[0] = PAT_U;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dig_sel !== 4'b1110 || seg_out !== PAT_U) begin
      errors++;
      $display("FAIL live_before got sel=%b seg=%b want 1110/%b", dig_sel, seg_out, PAT_U);
    end
    segs[0] = PAT_P;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dig_sel !== 4'b1110 || seg_out !== PAT_P) begin
        errors++;
        $display("FAIL live_after got sel=%b seg=%b want 1110/%b", dig_sel, seg_out, PAT_P);
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp_out) begin
        errors++;
        $display("FAIL random got %b want %b", {frame_tick, dig_sel, seg_out}, exp_out);
      end
      checks++;
      if (!$onehot0(~dig_sel) || (dig_sel === 4'b1111 && seg_out !== 7'd0)) begin
        errors++;
        $display("FAIL random_invariant got sel=%b seg=%b want <=1 low, blank when idle",
                 dig_sel, seg_out);
      end
      if ($urandom_range(0, 5) == 0) segs[$urandom_range(0, 3)] = 7'($urandom);
      if ($urandom_range(0, 20) == 0) blink_en = 4'($urandom);
      enable = ($urandom_range(0, 149) != 0);
    end
  endtask

  initial begin
    segs[0] = 7'd0; segs[1] = 7'd0; segs[2] = 7'd0; segs[3] = 7'd0;
    test_reset();
    test_scan();
    test_blink();
    test_enable();
    test_live();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
